gan_infer_ctrl: RTL and testbench

//  Sequencer for the 8-layer GAN_pipelined datapath. Loads the 73 signed 6-bit weights/biases serially into a parameter bank.

---
 rtl/gan_pkg.sv | 38 +++
 rtl/gan_param_bank.sv | 36 +++
 rtl/gan_infer_ctrl.sv | 149 ++++++++++++++
 tb/tb_gan_infer_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gan_pkg.sv
// Shared definitions for the GAN inference controller slice.
// Holds parameter-bank geometry, datapath word widths, the controller state
// encoding and the per-layer base offsets of the flattened parameter bank.
// Layer layout inside the bank (weights first, then biases, per layer):
//   L1 @0 (w11..w44 row-major, b1..b4), L2 @20, L3 @30, L4 @33,
//   L5 @35, L6 @37, L7 @41, L8 @53; 73 words total.
package gan_pkg;

  localparam int PW = 6;   // parameter / input element width
  localparam int FW = 32;  // result element width
  localparam int XW = 4 * PW;
  localparam int FBW = 4 * FW;

  // Each base is the previous base plus that layer's word count.
  localparam int L1_BASE = 0;
  localparam int L2_BASE = L1_BASE + 20;
  localparam int L3_BASE = L2_BASE + 10;
  localparam int L4_BASE = L3_BASE + 3;
  localparam int L5_BASE = L4_BASE + 2;
  localparam int L6_BASE = L5_BASE + 2;
  localparam int L7_BASE = L6_BASE + 4;
  localparam int L8_BASE = L7_BASE + 12;
  localparam int NUM_PARAMS = L8_BASE + 20;

  localparam int LDW = 7;  // load counter width, covers 0..NUM_PARAMS-1
  localparam int BANKW = NUM_PARAMS * PW;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic is_last_word(input logic [LDW-1:0] idx);
    return idx == LDW'(NUM_PARAMS - 1);
  endfunction

endpackage

// File: rtl/gan_param_bank.sv
// 73 x 6-bit parameter register file for the GAN datapath.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; clears every entry
//   we     - write enable
//   waddr  - write index (0..NUM_PARAMS-1)
//   wdata  - signed parameter word
//   rdata  - all entries flattened, index 0 at the LSBs
module gan_param_bank
  import gan_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [LDW-1:0]   waddr,
  input  logic [PW-1:0]    wdata,
  output logic [BANKW-1:0] rdata
);

  logic [PW-1:0] mem [NUM_PARAMS];

  // NOTE: this storage is reset on purpose -- the datapath reads every entry
  // continuously, so a freshly reset bank must present all-zero parameters.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) mem[i] <= '0;
    end else if (we && (waddr < LDW'(NUM_PARAMS))) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_rd
    assign rdata[g*PW +: PW] = mem[g];
  end

endmodule

// File: rtl/gan_infer_ctrl.sv
// Sequencer for the 8-layer pipelined GAN datapath.
// Loads the 73-word parameter set serially, issues input vectors into the
// datapath through a valid/ready handshake, tracks in-flight vectors with a
// shift register and returns results with output backpressure (a stalled
// output freezes the whole pipe via dp_enable).
// Ports:
//   clock, reset           - rising-edge clock, synchronous active-high reset
//   load_start             - request a parameter reload (honoured in RUN only)
//   wr_valid/wr_ready/wr_data - parameter word stream, fixed load order
//   in_valid/in_ready/in_x - input vectors {x4,x3,x2,x1}
//   dp_x, dp_params, dp_enable, dp_f - datapath interface
//   out_valid/out_ready/out_f - results {f4,f3,f2,f1}
//   loaded                 - full parameter set present
//   perf_done, perf_stall  - delivered-result / stall-cycle counters
// Configuration:
//   GAN_CTRL_PERF_EN - when defined, builds the saturating perf counters;
//                      otherwise both counters are tied to zero.
module gan_infer_ctrl
  import gan_pkg::*;
#(
  parameter int PIPE_LAT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_start,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PW-1:0]    wr_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XW-1:0]    in_x,
  output logic [XW-1:0]    dp_x,
  output logic [BANKW-1:0] dp_params,
  output logic             dp_enable,
  input  logic [FBW-1:0]   dp_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FBW-1:0]   out_f,
  output logic             loaded,
  output logic [31:0]      perf_done,
  output logic [31:0]      perf_stall
);

  state_t              state_q, state_d;
  logic [LDW-1:0]      ld_cnt_q;
  logic [PIPE_LAT-1:0] vld_sr_q;
  logic                loaded_q;
  logic                stall;
  logic                wr_fire;
  logic                in_fire;
  logic                pipe_empty;

  assign dp_x       = in_x;
  assign out_f      = dp_f;
  assign loaded     = loaded_q;
  assign out_valid  = vld_sr_q[PIPE_LAT-1];
  assign stall      = out_valid & ~out_ready;
  assign pipe_empty = (vld_sr_q == '0);
  // Decoded from the state register directly so it does not loop through
  // the combinational output block.
  assign wr_fire    = wr_valid & (state_q == ST_LOAD);
  assign in_fire    = in_valid & in_ready;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    wr_ready  = 1'b0;
    in_ready  = 1'b0;
    dp_enable = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        wr_ready = 1'b1;
        if (wr_fire && is_last_word(ld_cnt_q)) state_d = ST_RUN;
      end
      ST_RUN: begin
        dp_enable = ~stall;
        in_ready  = ~stall;
        if (load_start) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Pipe keeps advancing with bubbles; the bank is only rewritten
        // once nothing is in flight.
        dp_enable = ~stall;
        if (pipe_empty) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      ld_cnt_q <= '0;
      vld_sr_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_fire) begin
        if (is_last_word(ld_cnt_q)) begin
          ld_cnt_q <= '0;
          loaded_q <= 1'b1;
        end else begin
          ld_cnt_q <= ld_cnt_q + LDW'(1);
        end
      end
      if ((state_q == ST_DRAIN) && pipe_empty) loaded_q <= 1'b0;
      // Occupancy moves in lockstep with the datapath; a bubble enters
      // whenever no vector is accepted on an enabled cycle.
      if (dp_enable) vld_sr_q <= {vld_sr_q[PIPE_LAT-2:0], in_fire};
    end
  end

  gan_param_bank u_bank (
    .clock (clock),
    .reset (reset),
    .we    (wr_fire),
    .waddr (ld_cnt_q),
    .wdata (wr_data),
    .rdata (dp_params)
  );

`ifdef GAN_CTRL_PERF_EN
  logic [31:0] perf_done_q;
  logic [31:0] perf_stall_q;

  // Counters saturate and survive reloads; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_done_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (out_valid && out_ready && (perf_done_q != '1))
        perf_done_q <= perf_done_q + 32'd1;
      if ((state_q != ST_LOAD) && stall && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_done  = perf_done_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_done  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_gan_infer_ctrl.sv
// Self-checking bench for gan_infer_ctrl.
// A stand-in datapath (PIPE_LAT-deep register chain gated by dp_enable)
// produces dp_f from the vector it carries and the current parameter bank.
// The reference model tracks accepted vectors in a queue, each tagged with
// the number of enabled cycles seen when it was accepted; a vector is due
// at the output once PIPE_LAT more enabled cycles have elapsed.
// Honours GAN_CTRL_PERF_EN for the perf counter expectations.
module tb_gan_infer_ctrl;

  localparam int PIPE_LAT = 8;
  localparam int NP = 73;

  typedef enum {M_LOAD, M_RUN, M_DRAIN} mode_t;
  typedef struct {
    logic [23:0] x;
    int          tag;
  } ent_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         load_start;
  logic         wr_valid;
  logic         wr_ready;
  logic [5:0]   wr_data;
  logic         in_valid;
  logic         in_ready;
  logic [23:0]  in_x;
  logic [23:0]  dp_x;
  logic [437:0] dp_params;
  logic         dp_enable;
  logic [127:0] dp_f;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_f;
  logic         loaded;
  logic [31:0]  perf_done;
  logic [31:0]  perf_stall;

  always #5 clock = ~clock;

  gan_infer_ctrl #(.PIPE_LAT(PIPE_LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .dp_x       (dp_x),
    .dp_params  (dp_params),
    .dp_enable  (dp_enable),
    .dp_f       (dp_f),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .loaded     (loaded),
    .perf_done  (perf_done),
    .perf_stall (perf_stall)
  );

  // Result function shared by the stand-in datapath and the expectations.
  function automatic logic [127:0] fmap(input logic [23:0] x, input int s);
    logic [127:0] r;
    for (int i = 0; i < 4; i++)
      r[i*32 +: 32] = 32'(int'($signed(x[i*6 +: 6])) * 7919 + s * (i + 3) + i);
    return r;
  endfunction

  function automatic int psum_bus(input logic [437:0] p);
    int s = 0;
    for (int i = 0; i < NP; i++) s += int'($signed(p[i*6 +: 6]));
    return s;
  endfunction

  logic [23:0] dp_stage [PIPE_LAT];
  always @(posedge clock) begin
    if (dp_enable) begin
      for (int i = PIPE_LAT - 1; i > 0; i--) dp_stage[i] <= dp_stage[i-1];
      dp_stage[0] <= dp_x;
    end
  end
  assign dp_f = fmap(dp_stage[PIPE_LAT-1], psum_bus(dp_params));

  // Reference model state.
  ent_t        q[$];
  mode_t       m_mode;
  int          m_cnt;
  logic        m_loaded;
  logic [5:0]  m_words [NP];
  int          en_count;
  int          m_done;
  int          m_stall;
  int          dut_done;
  int          dut_en_low;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_psum();
    int s = 0;
    for (int i = 0; i < NP; i++) s += int'($signed(m_words[i]));
    return s;
  endfunction

  function automatic logic [437:0] m_bank();
    logic [437:0] b;
    for (int i = 0; i < NP; i++) b[i*6 +: 6] = m_words[i];
    return b;
  endfunction

  function automatic logic m_valid();
    return (q.size() > 0) && (q[0].tag + PIPE_LAT == en_count);
  endfunction

  // One clock cycle: compare at the falling edge against the model, advance
  // the model with the handshakes it predicts, then return just after the
  // rising edge so the caller can drive the next cycle's inputs.
  task automatic step();
    logic ev, st, en, ir, wr;
    int   pre_sz;
    @(negedge clock);
    pre_sz = q.size();
    ev = m_valid();
    st = ev && !out_ready;
    en = (m_mode != M_LOAD) && !st;
    ir = (m_mode == M_RUN) && !st;
    wr = (m_mode == M_LOAD);
    check("out_valid", out_valid, ev);
    check("dp_enable", dp_enable, en);
    check("in_ready", in_ready, ir);
    check("wr_ready", wr_ready, wr);
    check("loaded", loaded, m_loaded);
    check("dp_x", dp_x, in_x);
    if (ev) check("out_f", out_f, fmap(q[0].x, m_psum()));
    if (out_valid && out_ready) dut_done++;
    if (!dp_enable) dut_en_low++;
    if (st && m_mode != M_LOAD) m_stall++;
    if (ev && out_ready) begin
      void'(q.pop_front());
      m_done++;
    end
    if (en) begin
      if (ir && in_valid) q.push_back('{x: in_x, tag: en_count});
      en_count++;
    end
    case (m_mode)
      M_LOAD: if (wr_valid) begin
        m_words[m_cnt] = wr_data;
        m_cnt++;
        if (m_cnt == NP) begin
          m_cnt = 0;
          m_loaded = 1'b1;
          m_mode = M_RUN;
        end
      end
      M_RUN:   if (load_start) m_mode = M_DRAIN;
      M_DRAIN: if (pre_sz == 0) begin
        m_mode = M_LOAD;
        m_loaded = 1'b0;
      end
      default: ;
    endcase
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load_start = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    m_mode = M_LOAD;
    m_cnt = 0;
    m_loaded = 1'b0;
    en_count = 0;
    m_done = 0;
    m_stall = 0;
    for (int i = 0; i < NP; i++) m_words[i] = '0;
  endtask

  task automatic rand_side_inputs();
    in_valid = 1'($urandom_range(0, 1));
    in_x = 24'($urandom);
    load_start = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
  endtask

  // Loads a random parameter set; stray in_valid/load_start must be ignored.
  task automatic load_set();
    int guard = 0;
    while (m_cnt < NP - 1 && guard < 2000) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data = 6'($urandom);
      rand_side_inputs();
      step();
      guard++;
    end
    check("load_bound", guard < 2000, 1);
    in_valid = 1'b1;
    wr_valid = 1'b0;
    #1;
    check("ld72_in_ready", in_ready, 0);
    check("ld72_loaded", loaded, 0);
    check("ld72_wr_ready", wr_ready, 1);
    wr_valid = 1'b1;
    wr_data = 6'($urandom);
    step();
    wr_valid = 1'b0;
    in_valid = 1'b0;
    load_start = 1'b0;
    out_ready = 1'b1;
    #1;
    check("ld73_loaded", loaded, 1);
    check("ld73_in_ready", in_ready, 1);
    check("ld73_wr_ready", wr_ready, 0);
    check("ld_params", dp_params, m_bank());
  endtask

  task automatic backpressure();
    int held = 0;
    int guard = 0;
    int d0 = dut_done;
    int e0 = dut_en_low;
    load_start = 1'b0;
    wr_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_x = 24'($urandom);
      step();
    end
    in_valid = 1'b0;
    while ((dut_done - d0) < 4 && guard < 100) begin
      out_ready = !(m_valid() && held < 5);
      if (!out_ready) held++;
      step();
      guard++;
    end
    check("bp_bound", guard < 100, 1);
    check("bp_delivered", dut_done - d0, 4);
    check("bp_enable_low", dut_en_low - e0, 5);
`ifdef GAN_CTRL_PERF_EN
    check("bp_perf_done", perf_done, 4);
    check("bp_perf_stall", perf_stall, 5);
`else
    check("bp_perf_done", perf_done, 0);
    check("bp_perf_stall", perf_stall, 0);
`endif
  endtask

  task automatic reload_and_golden();
    int guard = 0;
    int d0 = dut_done;
    logic [23:0] gx;
    out_ready = 1'b1;
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_x = 24'($urandom);
      load_start = (i == 2);
      step();
    end
    load_start = 1'b0;
    #1;
    check("drain_in_ready", in_ready, 0);
    check("drain_wr_ready", wr_ready, 0);
    while (m_mode != M_LOAD && guard < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      wr_valid = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    check("drain_bound", guard < 100, 1);
    check("drain_delivered", dut_done - d0, 3);
    in_valid = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("reload_wr_ready", wr_ready, 1);
    check("reload_loaded", loaded, 0);
    load_set();
    // Golden vector x1=0, x2=1, x3=1, x4=0 against the freshly loaded set.
    gx = {6'd0, 6'd1, 6'd1, 6'd0};
    in_x = gx;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int j = 1; j <= PIPE_LAT; j++) begin
      check("golden_latency", out_valid, (j == PIPE_LAT));
      if (j < PIPE_LAT) step();
    end
    check("golden_f", out_f, fmap(gx, m_psum()));
    step();
  endtask

  task automatic reset_mid_run();
    out_ready = 1'b1;
    wr_valid = 1'b0;
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_x = 24'($urandom);
      step();
    end
    check("pre_rst_loaded", loaded, 1);
    do_reset();
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_loaded", loaded, 0);
    check("rst_mid_wr_ready", wr_ready, 1);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_params", dp_params, 0);
    check("rst_mid_perf_done", perf_done, 0);
  endtask

  initial begin
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_loaded", loaded, 0);
    check("rst_dp_enable", dp_enable, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_params", dp_params, 0);
    check("rst_perf_done", perf_done, 0);
    check("rst_perf_stall", perf_stall, 0);

    load_set();
    backpressure();
    reload_and_golden();
    reset_mid_run();
    load_set();

    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_x = 24'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      load_start = ($urandom_range(0, 49) == 0);
      wr_valid = 1'($urandom_range(0, 1));
      wr_data = 6'($urandom);
      step();
    end

`ifdef GAN_CTRL_PERF_EN
    check("final_perf_done", perf_done, m_done);
    check("final_perf_stall", perf_stall, m_stall);
`else
    check("final_perf_done", perf_done, 0);
    check("final_perf_stall", perf_stall, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
